// File: rtl/mul_fu_sched.sv
// rtl/mul_fu_sched.sv - shared multi-cycle MUL/DIV unit scheduler for the multiply reservation stations
// Define MUL_SCHED_RR_EN for round-robin station selection; otherwise the lowest ready index wins.
module mul_fu_sched #(
    parameter int NUM_RS  = 2,
    parameter int MUL_LAT = 10,
    parameter int DIV_LAT = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RS-1:0]    rs_ready,
    input  logic [3*NUM_RS-1:0]  rs_op,
    input  logic [32*NUM_RS-1:0] rs_vj,
    input  logic [32*NUM_RS-1:0] rs_vk,
    input  logic [4*NUM_RS-1:0]  rs_tag,
    output logic [NUM_RS-1:0]    rs_grant,
    output logic [NUM_RS-1:0]    rs_done,
    output logic                 cdb_req,
    input  logic                 cdb_grant,
    output logic [3:0]           cdb_tag,
    output logic [31:0]          cdb_data,
    output logic                 fu_busy
);

    localparam int IDXW   = $clog2(NUM_RS);
    localparam int NSLOT  = 1 << IDXW;
    localparam int MAXLAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);
    localparam logic [2:0] OP_MUL = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       vj_q, vj_d;
    logic [31:0]       vk_q, vk_d;
    logic [3:0]        tag_q, tag_d;
    logic [31:0]       result_q, result_d;
    logic [NUM_RS-1:0] grant_q, grant_d;

    logic              sel_valid;
    logic [IDXW-1:0]   sel_idx;
    logic [NSLOT-1:0]  ready_pad;
    logic [2:0]        op_a  [NSLOT];
    logic [31:0]       vj_a  [NSLOT];
    logic [31:0]       vk_a  [NSLOT];
    logic [3:0]        tag_a [NSLOT];
    logic [31:0]       mul_res;
    logic [31:0]       div_res;
    logic [NUM_RS-1:0] one_hot_base;

    assign one_hot_base = {{(NUM_RS-1){1'b0}}, 1'b1};

    // Per-station slices, padded to a power of two so any index value is in range.
    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        if (g < NUM_RS) begin : g_real
            assign ready_pad[g] = rs_ready[g];
            assign op_a[g]      = rs_op[3*g +: 3];
            assign vj_a[g]      = rs_vj[32*g +: 32];
            assign vk_a[g]      = rs_vk[32*g +: 32];
            assign tag_a[g]     = rs_tag[4*g +: 4];
        end else begin : g_pad
            assign ready_pad[g] = 1'b0;
            assign op_a[g]      = 3'd0;
            assign vj_a[g]      = 32'd0;
            assign vk_a[g]      = 32'd0;
            assign tag_a[g]     = 4'd0;
        end
    end

`ifdef MUL_SCHED_RR_EN
    logic [IDXW-1:0] last_q, last_d;
    logic [IDXW-1:0] cand;

    // Scan downward from the farthest candidate so the nearest ready station after last_q wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NUM_RS; k >= 1; k--) begin
            cand = IDXW'((int'(last_q) + k) % NUM_RS);
            if (ready_pad[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == ST_IDLE && sel_valid) begin
            last_d = sel_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IDXW'(NUM_RS - 1);
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = NUM_RS - 1; k >= 0; k--) begin
            if (ready_pad[IDXW'(k)]) begin
                sel_valid = 1'b1;
                sel_idx   = IDXW'(k);
            end
        end
    end
`endif

    assign mul_res = vj_q * vk_q;
    assign div_res = (vk_q == 32'd0) ? 32'hFFFF_FFFF : (vj_q / vk_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        op_d     = op_q;
        vj_d     = vj_q;
        vk_d     = vk_q;
        tag_d    = tag_q;
        result_d = result_q;
        grant_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_d = ST_EXEC;
                    owner_d = sel_idx;
                    op_d    = op_a[sel_idx];
                    vj_d    = vj_a[sel_idx];
                    vk_d    = vk_a[sel_idx];
                    tag_d   = tag_a[sel_idx];
                    cnt_d   = (op_a[sel_idx] == OP_MUL) ? CW'(MUL_LAT - 1) : CW'(DIV_LAT - 1);
                    grant_d = one_hot_base << sel_idx;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    result_d = (op_q == OP_MUL) ? mul_res : div_res;
                    state_d  = ST_WB;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_WB: begin
                if (cdb_grant) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            owner_q  <= '0;
            op_q     <= 3'd0;
            vj_q     <= 32'd0;
            vk_q     <= 32'd0;
            tag_q    <= 4'd0;
            result_q <= 32'd0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            vj_q     <= vj_d;
            vk_q     <= vk_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            grant_q  <= grant_d;
        end
    end

    // Result and tag are forced to zero outside WB so the CDB mux sees a quiet source.
    assign fu_busy  = (state_q != ST_IDLE);
    assign cdb_req  = (state_q == ST_WB);
    assign cdb_tag  = cdb_req ? tag_q : 4'd0;
    assign cdb_data = cdb_req ? result_q : 32'd0;
    assign rs_done  = (cdb_req && cdb_grant) ? (one_hot_base << owner_q) : '0;
    assign rs_grant = grant_q;

endmodule
